clk_div_sequencer: RTL and testbench
====================================

CLK_DIV_SEQUENCER -- requirements
Module: clk_div_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port run, input, 1 bit: 1 = divider counting, 0 = divider held idle.
REQ-004 SHALL have port cfg_req, input, 1 bit: ratio-change request, 4-phase level handshake.
REQ-005 SHALL have port cfg_sel, input, 3 bits: requested ratio code, divide-by = 2^(cfg_sel+1) for codes 0..4.
REQ-006 SHALL have port cfg_ack, output, 1 bit: one-cycle pulse completing a request.
REQ-007 SHALL have port err, output, 1 bit: one-cycle pulse, coincident with cfg_ack, marking a rejected code.
REQ-008 SHALL have port busy, output, 1 bit: 1 while an accepted request waits for a period boundary.
REQ-009 SHALL have port cur_sel, output, 3 bits: ratio code currently applied.
REQ-010 SHALL have port div_out, output, 1 bit: divided clock, 50% duty.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse in the last cycle of each divided period.

Function
REQ-012 SHALL hold a 5-bit counter cnt and a state register with states IDLE, RUN, PEND and WAITLOW.
REQ-013 In RUN/PEND, cnt SHALL increment each cycle and wrap from N-1 to 0, where N = 2^(cur_sel+1).
REQ-014 div_out SHALL equal cnt[cur_sel] and tick SHALL equal (cnt == N-1) AND state in {RUN, PEND}; both are decoded from registered state with no added latency.
REQ-015 In IDLE, cnt SHALL be 0, div_out 0, tick 0; IDLE->RUN on run=1; RUN/PEND->IDLE on run=0 at the next edge, cnt cleared.
REQ-016 A request SHALL be accepted when cfg_req=1 in IDLE or RUN; cfg_sel is captured at that edge, and later cfg_sel changes are ignored.
REQ-017 A code of 5..7 SHALL be rejected: cfg_ack=1 and err=1 at the next edge, cur_sel unchanged, state->WAITLOW.
REQ-018 A valid request accepted in IDLE SHALL load cur_sel and pulse cfg_ack at the next edge; state->WAITLOW.
REQ-019 A valid request accepted in RUN SHALL move state to PEND (busy=1); at the edge where cnt==N-1 it SHALL load cur_sel, set cnt=0, pulse cfg_ack, and move to WAITLOW, so that no shortened or runt period of div_out occurs.
REQ-020 If run falls while in PEND, the pending code SHALL be applied and acked at that edge, with state->IDLE via WAITLOW semantics; the request is never lost.
REQ-021 WAITLOW SHALL keep counting as RUN if run=1 (idle if run=0) and SHALL accept no request until cfg_req=0 is sampled, then return to RUN or IDLE per run.
REQ-022 A request to the same code as cur_sel SHALL be acked by the same rules, with no disturbance to cnt.

Reset
REQ-023 While rst=0: state=IDLE, cnt=0, cur_sel=0 (divide-by-2), cfg_ack=0, err=0, busy=0, div_out=0, tick=0; any pending request is discarded without ack.
REQ-024 Reset release SHALL take effect on the first rising clk edge after rst rises; no output may change before that edge.

Configuration
REQ-025 With CLKDIV_PERIOD_CNT_EN defined, output period_cnt[15:0] SHALL count tick pulses, saturate at 0xFFFF, and clear to 0 on reset and on every cur_sel load.
REQ-026 Without CLKDIV_PERIOD_CNT_EN, the period_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset, run=1, cur_sel=0 -> div_out toggles every cycle, tick high on every odd cnt, for 8 cycles.
REQ-028 In RUN at divide-by-2, request cfg_sel=4 -> busy until cnt==1, cfg_ack at the boundary, then div_out low 16 cycles / high 16 cycles, tick every 32 cycles.
REQ-029 cfg_sel=6 request in RUN -> cfg_ack=err=1 for one cycle, cur_sel unchanged, cnt sequence unbroken.
REQ-030 PEND at divide-by-32 with cnt=5, drop run -> cfg_ack at next edge, cur_sel=new code, cnt=0, div_out=0.
REQ-031 Hold cfg_req=1 for 10 cycles after ack -> exactly one cfg_ack; a second request is accepted only after cfg_req goes 0.
REQ-032 Assert rst mid-PEND at divide-by-8 -> all outputs reset immediately, no cfg_ack; with CLKDIV_PERIOD_CNT_EN defined, period_cnt=0.

Source files
------------

// File: rtl/clk_div_sequencer.sv
// Programmable power-of-two clock divider whose ratio is changed only on period boundaries.
// Optional tick counter enabled by defining CLKDIV_PERIOD_CNT_EN.
module clk_div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        cfg_req,
  input  logic [2:0]  cfg_sel,
  output logic        cfg_ack,
  output logic        err,
  output logic        busy,
  output logic [2:0]  cur_sel,
  output logic        div_out,
  output logic        tick,
`ifdef CLKDIV_PERIOD_CNT_EN
  output logic [15:0] period_cnt,
`endif
  output logic [1:0]  state_dbg
);

  // cfg_req/cfg_ack handshake: the requester raises cfg_req with cfg_sel stable, the block
  // captures cfg_sel on the accepting edge, later pulses cfg_ack for one cycle (with err on
  // a rejected code), and will not accept another request until cfg_req is seen low.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PEND    = 2'd2,
    WAITLOW = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n, cnt_inc, last_cnt;
  logic [5:0]  period_n;
  logic [2:0]  sel_n, pend_sel, pend_n;
  logic        ack_n, err_n, wrap, bad_code;

  assign period_n  = 6'd2 << cur_sel;
  assign last_cnt  = 5'(period_n - 6'd1);
  assign wrap      = (cnt == last_cnt);
  assign cnt_inc   = wrap ? 5'd0 : cnt + 5'd1;
  assign bad_code  = (cfg_sel > 3'd4);

  assign busy      = (state == PEND);
  assign div_out   = cnt[cur_sel];
  assign tick      = ((state == RUN) || (state == PEND)) && wrap;
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = cur_sel;
    pend_n  = pend_sel;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 5'd0;
        if (cfg_req) begin
          ack_n   = 1'b1;
          err_n   = bad_code;
          if (!bad_code) sel_n = cfg_sel;
          state_n = WAITLOW;
        end else if (run) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          cnt_n   = 5'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          if (cfg_req) begin
            if (bad_code) begin
              ack_n   = 1'b1;
              err_n   = 1'b1;
              state_n = WAITLOW;
            end else begin
              pend_n  = cfg_sel;
              state_n = PEND;
            end
          end
        end
      end
      PEND: begin
        // Apply on the last cycle of a period so div_out never shows a runt half-cycle.
        if (!run || wrap) begin
          sel_n   = pend_sel;
          cnt_n   = 5'd0;
          ack_n   = 1'b1;
          state_n = WAITLOW;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      WAITLOW: begin
        cnt_n = run ? cnt_inc : 5'd0;
        if (!cfg_req) state_n = run ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      cur_sel  <= 3'd0;
      pend_sel <= 3'd0;
      cfg_ack  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_sel  <= sel_n;
      pend_sel <= pend_n;
      cfg_ack  <= ack_n;
      err      <= err_n;
    end
  end

`ifdef CLKDIV_PERIOD_CNT_EN
  logic load;
  assign load = ack_n & ~err_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                period_cnt <= 16'd0;
    else if (load)                           period_cnt <= 16'd0;
    else if (tick && period_cnt != 16'hFFFF) period_cnt <= period_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed + randomized bench for clk_div_sequencer against a period-position reference model.
module tb_clk_div_sequencer;

  logic        clk, rst, run, cfg_req;
  logic [2:0]  cfg_sel;
  logic        cfg_ack, err, busy, div_out, tick;
  logic [2:0]  cur_sel;
  logic [1:0]  state_dbg;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  clk_div_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .cfg_ack(cfg_ack), .err(err), .busy(busy), .cur_sel(cur_sel),
    .div_out(div_out), .tick(tick),
`ifdef CLKDIV_PERIOD_CNT_EN
    .period_cnt(period_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // reference model: applied ratio, position inside the current period, pending code
  int m_sel, m_pos, m_pend, m_pc;
  bit m_active, m_hold, m_ack, m_err;

  function automatic int per(input int s);
    return 2 << s;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_pos = 0; m_pend = -1; m_pc = 0;
    m_active = 0; m_hold = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit r, input bit q, input int s);
    int n;
    bit t, ld;
    n  = per(m_sel);
    t  = m_active && !m_hold && (m_pos == n - 1);
    ld = 0;
    m_ack = 0; m_err = 0;
    if (m_hold) begin
      if (!q) m_hold = 0;
      m_active = r;
      m_pos = r ? (m_pos + 1) % n : 0;
    end else if (m_pend >= 0) begin
      if (!r || m_pos == n - 1) begin
        m_sel = m_pend; m_pend = -1; m_pos = 0;
        m_active = r; m_hold = 1; m_ack = 1; ld = 1;
      end else begin
        m_pos++;
      end
    end else if (!m_active) begin
      m_pos = 0;
      if (q) begin
        m_ack = 1; m_hold = 1;
        if (s > 4) m_err = 1;
        else begin m_sel = s; ld = 1; end
      end else if (r) begin
        m_active = 1;
      end
    end else begin
      if (!r) begin
        m_active = 0; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % n;
        if (q) begin
          if (s > 4) begin m_ack = 1; m_err = 1; m_hold = 1; end
          else m_pend = s;
        end
      end
    end
    if (ld) m_pc = 0;
    else if (t && m_pc < 65535) m_pc++;
  endtask

  // scoreboard
  task automatic check(input string tag);
    logic [7:0] exp_v, obs_v;
    int n;
    bit div_e, tick_e;
    n      = per(m_sel);
    div_e  = (m_pos >= n / 2);
    tick_e = m_active && !m_hold && (m_pos == n - 1);
    exp_q.push_back({m_ack, m_err, (m_pend >= 0), 3'(m_sel), div_e, tick_e});
    obs_v = {cfg_ack, err, busy, cur_sel, div_out, tick};
    exp_v = exp_q.pop_front();
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s t=%0t observed{ack,err,busy,sel,div,tick}=%b expected=%b", tag, $time, obs_v, exp_v);
    end
`ifdef CLKDIV_PERIOD_CNT_EN
    total++;
    assert (period_cnt === 16'(m_pc)) else begin
      bad++;
      $error("FAIL %s_pcnt t=%0t observed=%0d expected=%0d", tag, $time, period_cnt, m_pc);
    end
`endif
  endtask

  // driver tasks
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(run, cfg_req, int'(cfg_sel));
    #1;
    check(tag);
    @(negedge clk);
  endtask

  task automatic steps(input int k, input string tag);
    for (int i = 0; i < k; i++) step(tag);
  endtask

  task automatic request_until_ack(input logic [2:0] sel, input string tag);
    cfg_req = 1'b1;
    cfg_sel = sel;
    step(tag);
    for (int i = 0; i < 80 && !m_ack; i++) begin
      cfg_sel = 3'($urandom_range(0, 7));
      step(tag);
    end
    cfg_req = 1'b0;
    step({tag, "_low"});
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; cfg_req = 1'b0; cfg_sel = 3'd0;
    model_reset();
    #1;
    check("reset");

    // release with run already high: nothing moves before the first edge
    @(negedge clk);
    rst = 1'b1; run = 1'b1;
    #1;
    check("release_hold");
    step("release_edge");
    steps(8, "div2_toggle");

    // divide-by-2 to divide-by-32 on a period boundary, then a few full periods
    request_until_ack(3'd4, "to_div32");
    steps(70, "div32_run");

    // rejected code: err with ack, count undisturbed
    request_until_ack(3'd6, "bad_code");
    steps(10, "after_bad");

    // run drops while pending at cnt 5
    cfg_req = 1'b1; cfg_sel = 3'd2;
    step("pend_req");
    for (int i = 0; i < 40 && !(m_pend >= 0 && m_pos == 5); i++) step("pend_wait");
    run = 1'b0;
    step("pend_run_drop");
    cfg_req = 1'b0;
    steps(3, "idle_after_drop");

    // request held high long after ack: only one ack, next request after release
    run = 1'b1;
    steps(5, "div8_run");
    cfg_req = 1'b1; cfg_sel = 3'd1;
    steps(20, "held_req");
    cfg_req = 1'b0;
    step("held_release");
    request_until_ack(3'd3, "second_req");
    steps(6, "div16_run");

    // same code as applied: ack without a disturbed count
    request_until_ack(3'd3, "same_code");
    steps(20, "same_code_run");

    // random mix of run, requests, aborts and changing codes
    for (int i = 0; i < 600; i++) begin
      run = ($urandom_range(0, 15) != 0);
      if (!cfg_req) begin
        if ($urandom_range(0, 5) == 0) begin
          cfg_req = 1'b1;
          cfg_sel = 3'($urandom_range(0, 7));
        end
      end else begin
        cfg_sel = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) cfg_req = 1'b0;
      end
      step("random");
    end

    // async reset while pending at divide-by-8
    cfg_req = 1'b0; run = 1'b0;
    steps(3, "pre_pend8");
    request_until_ack(3'd2, "load_div8");
    run = 1'b1;
    steps(4, "div8_again");
    cfg_req = 1'b1; cfg_sel = 3'd0;
    step("pend8_req");
    step("pend8_wait");
    rst = 1'b0;
    #1;
    model_reset();
    check("reset_mid_pend");
    @(negedge clk);
    cfg_req = 1'b0;
    #1;
    check("reset_held");
    @(negedge clk);
    rst = 1'b1;
    steps(6, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
